// File: rtl/cp0_unit_pkg.sv
// cp0_unit_pkg
// Shared pipeline definitions for the coprocessor-0 block: CP0 register
// numbers, exception codes, the default exception entry vector, the
// writable-bit mask of the Status register and the EPC helper.
// Ports: none (package).
package cp0_unit_pkg;

  // CP0 register numbers used by mtc0/mfc0
  localparam logic [4:0] CP0_REG_SR    = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE = 5'd13;
  localparam logic [4:0] CP0_REG_EPC   = 5'd14;
  localparam logic [4:0] CP0_REG_PRID  = 5'd15;

  // Exception codes carried down the pipeline; 0 doubles as "none" on excode_m
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;

  // Status bits that exist: IM[15:10], EXL[1], IE[0]
  localparam logic [31:0] SR_WMASK = 32'h0000_FC03;

  // Return address: word-aligned PC, backed up one word for a delay slot so
  // eret re-executes the branch.
  function automatic logic [31:0] exc_epc(input logic [31:0] pc, input logic bd);
    logic [31:0] pc_al;
    pc_al = pc & 32'hFFFF_FFFC;
    return bd ? (pc_al - 32'd4) : pc_al;
  endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// cp0_unit_if
// Bundles the pipeline-side signals of the CP0 block (mtc0/mfc0 bus,
// M-stage exception inputs, interrupt lines and the redirect outputs).
// master: pipeline side (drives requests, receives dout/req/epc_out).
// slave : CP0 side (receives requests, drives dout/req/epc_out/handler_pc).
interface cp0_unit_if;
  import cp0_unit_pkg::*;

  logic        we;
  logic [4:0]  cp0_addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  excode_m;
  logic [5:0]  hwint;
  logic        eret;
  logic        req;
  logic [31:0] epc_out;
  logic [31:0] handler_pc;

  modport master (
    output we, cp0_addr, din, pc_m, bd_m, excode_m, hwint, eret,
    input  dout, req, epc_out, handler_pc
  );

  modport slave (
    input  we, cp0_addr, din, pc_m, bd_m, excode_m, hwint, eret,
    output dout, req, epc_out, handler_pc
  );

endinterface

// File: rtl/cp0_unit_irq_arb.sv
// cp0_irq_arb
// Combinational interrupt/exception arbiter for CP0.
// Inputs : hwint (raw interrupt lines), im/ie/exl (Status fields),
//          excode (M-stage exception code, 0 = none).
// Outputs: int_req, exc_req, req (either taken), exccode_sel (code to latch
//          into Cause; interrupts win over exceptions).
module cp0_irq_arb
  import cp0_unit_pkg::*;
(
  input  logic [5:0] hwint,
  input  logic [5:0] im,
  input  logic       ie,
  input  logic       exl,
  input  logic [4:0] excode,
  output logic       int_req,
  output logic       exc_req,
  output logic       req,
  output logic [4:0] exccode_sel
);

  always_comb begin
    int_req     = (|(hwint & im)) & ie & ~exl;
    exc_req     = (excode != EXC_NONE) & ~exl;
    req         = int_req | exc_req;
    exccode_sel = int_req ? EXC_INT : excode;
  end

endmodule

// File: rtl/cp0_unit.sv
// cp0_unit
// MIPS-style coprocessor 0: Status (12), Cause (13), EPC (14), PRId (15).
// Takes interrupts/exceptions from the M stage, records EPC/Cause, and
// provides the eret return address.
// Ports:
//   clk, reset (sync, active-low)
//   we, cp0_addr, din      : mtc0 write
//   dout                   : mfc0 read data (combinational, pre-edge state)
//   pc_m, bd_m, excode_m   : M-stage instruction info
//   hwint                  : level-sensitive interrupt lines
//   eret                   : eret in M stage
//   req                    : exception/interrupt taken this cycle (comb.)
//   epc_out                : eret target, bypassing a same-cycle EPC write
//   handler_pc             : constant entry vector
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] PRID_VAL   = 32'h0000_4350,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  excode_m,
  input  logic [5:0]  hwint,
  input  logic        eret,
  output logic        req,
  output logic [31:0] epc_out,
  output logic [31:0] handler_pc
);

  // Status fields
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  // Cause fields
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exccode_q, exccode_d;
  // EPC
  logic [31:0] epc_q, epc_d;

  logic [4:0]  excode_gated;
  logic        int_req_unused;
  logic        exc_req_unused;
  logic [4:0]  exccode_sel;

  // A stale exception code in the pipeline must not fire while in reset.
  assign excode_gated = reset ? excode_m : EXC_NONE;

  cp0_irq_arb u_arb (
    .hwint       (hwint),
    .im          (im_q),
    .ie          (ie_q),
    .exl         (exl_q),
    .excode      (excode_gated),
    .int_req     (int_req_unused),
    .exc_req     (exc_req_unused),
    .req         (req),
    .exccode_sel (exccode_sel)
  );

  assign handler_pc = HANDLER_PC;

  // Let eret in the same cycle as an mtc0 EPC use the freshly written value.
  assign epc_out = (we && (cp0_addr == CP0_REG_EPC)) ? din : epc_q;

  always_comb begin
    dout = 32'd0;
    case (cp0_addr)
      CP0_REG_SR:    dout = {16'd0, im_q, 8'd0, exl_q, ie_q};
      CP0_REG_CAUSE: dout = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'd0};
      CP0_REG_EPC:   dout = epc_q;
      CP0_REG_PRID:  dout = PRID_VAL;
      default:       dout = 32'd0;
    endcase
  end

  always_comb begin
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    bd_d      = bd_q;
    exccode_d = exccode_q;
    epc_d     = epc_q;
    // Pending lines are always visible, even while EXL masks them.
    ip_d      = hwint;

    if (req) begin
      // Exception entry wins over any coincident mtc0/eret.
      exl_d     = 1'b1;
      exccode_d = exccode_sel;
      bd_d      = bd_m;
      epc_d     = exc_epc(pc_m, bd_m);
    end else begin
      if (eret) begin
        exl_d = 1'b0;
      end
      if (we) begin
        case (cp0_addr)
          CP0_REG_SR: begin
            im_d  = din[15:10];
            exl_d = din[1];
            ie_d  = din[0];
          end
          CP0_REG_EPC: epc_d = din;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      im_q      <= 6'd0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      ip_q      <= 6'd0;
      exccode_q <= 5'd0;
      epc_q     <= 32'd0;
    end else begin
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      bd_q      <= bd_d;
      ip_q      <= ip_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h0000_4350;
  localparam logic [31:0] HPC  = 32'h0000_4180;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  cp0_unit_if bus();

  cp0_unit dut (
    .clk        (clk),
    .reset      (reset),
    .we         (bus.we),
    .cp0_addr   (bus.cp0_addr),
    .din        (bus.din),
    .dout       (bus.dout),
    .pc_m       (bus.pc_m),
    .bd_m       (bus.bd_m),
    .excode_m   (bus.excode_m),
    .hwint      (bus.hwint),
    .eret       (bus.eret),
    .req        (bus.req),
    .epc_out    (bus.epc_out),
    .handler_pc (bus.handler_pc)
  );

  always #5 clk = ~clk;

  // Reference state kept as whole architectural register words
  logic [31:0] m_sr, m_cause, m_epc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  // One clock cycle: drive, check combinational outputs mid-cycle, advance model.
  task automatic cyc(input logic rn, input logic w, input logic [4:0] a,
                     input logic [31:0] d, input logic [31:0] pc, input logic bd,
                     input logic [4:0] exc, input logic [5:0] hw, input logic er,
                     input bit chk_on, output logic obs_req, output logic [31:0] obs_epc);
    logic        i_r, e_r, r;
    logic [31:0] base;
    reset = rn; bus.we = w; bus.cp0_addr = a; bus.din = d; bus.pc_m = pc;
    bus.bd_m = bd; bus.excode_m = exc; bus.hwint = hw; bus.eret = er;
    #3;
    i_r = ((hw & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    e_r = rn && (exc != 5'd0) && !m_sr[1];
    r   = i_r || e_r;
    obs_req = bus.req;
    obs_epc = bus.epc_out;
    if (chk_on) begin
      chk("req", {31'd0, bus.req}, {31'd0, r});
      chk("dout", bus.dout, m_read(a));
      chk("epc_out", bus.epc_out, (w && a == 5'd14) ? d : m_epc);
    end
    if (!rn) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      m_cause[15:10] = hw;
      if (r) begin
        m_sr[1]       = 1'b1;
        m_cause[6:2]  = i_r ? 5'd0 : exc;
        m_cause[31]   = bd;
        base          = {pc[31:2], 2'b00};
        m_epc         = bd ? base - 32'd4 : base;
      end else begin
        if (er) m_sr[1] = 1'b0;
        if (w && a == 5'd12) m_sr = d & 32'h0000_FC03;
        if (w && a == 5'd14) m_epc = d;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
    bus.we = 1'b0;
    bus.cp0_addr = a;
    #1;
    chk(tag, bus.dout, exp);
  endtask

  initial begin
    logic        q;
    logic [31:0] e;
    logic        rw, rb, rer, rrn;
    logic [4:0]  ra, rx;
    logic [5:0]  rh;
    m_sr = 0; m_cause = 0; m_epc = 0;
    reset = 1'b0;
    bus.we = 0; bus.cp0_addr = 0; bus.din = 0; bus.pc_m = 0; bus.bd_m = 0;
    bus.excode_m = 0; bus.hwint = 0; bus.eret = 0;
    @(posedge clk); #1;

    // Reset, then a reset cycle with pending exception and interrupts
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, q, e);
    cyc(0, 0, 0, 0, 0, 0, 5'd10, 6'h3f, 0, 1, q, e);
    chk("reset_req", {31'd0, q}, 32'd0);
    rd(12, 0, "rst_sr"); rd(13, 0, "rst_cause"); rd(14, 0, "rst_epc"); rd(15, PRID, "prid");

    // Interrupt entry
    cyc(1, 1, 12, 32'h0000_0401, 0, 0, 0, 0, 0, 1, q, e);
    cyc(1, 0, 13, 0, 32'h0000_3000, 0, 0, 6'b000001, 0, 1, q, e);
    chk("int_req", {31'd0, q}, 32'd1);
    rd(13, 32'h0000_0400, "int_cause"); rd(12, 32'h0000_0403, "int_sr");
    rd(14, 32'h0000_3000, "int_epc");

    // eret clears EXL
    cyc(1, 0, 12, 0, 0, 0, 0, 0, 1, 1, q, e);
    rd(12, 32'h0000_0401, "eret_sr");

    // RI in delay slot
    cyc(1, 0, 14, 0, 32'h0000_3010, 1, 5'd10, 0, 0, 1, q, e);
    chk("ri_req", {31'd0, q}, 32'd1);
    rd(13, 32'h8000_0028, "ri_cause"); rd(14, 32'h0000_300C, "ri_epc");

    // Interrupt beats simultaneous exception; then exception masked by EXL
    cyc(1, 0, 12, 0, 0, 0, 0, 0, 1, 1, q, e);
    cyc(1, 0, 13, 0, 32'h0000_3040, 0, 5'd12, 6'b000001, 0, 1, q, e);
    rd(13, 32'h0000_0400, "prio_cause");
    cyc(1, 0, 13, 0, 32'h0000_3080, 0, 5'd12, 6'b000001, 0, 1, q, e);
    chk("exl_mask_req", {31'd0, q}, 32'd0);
    rd(12, 32'h0000_0403, "exl_sr"); rd(13, 32'h0000_0400, "exl_cause");
    rd(14, 32'h0000_3040, "exl_epc");

    // eret, then eret colliding with AdEL
    cyc(1, 0, 12, 0, 0, 0, 0, 0, 1, 1, q, e);
    cyc(1, 0, 12, 0, 32'h0000_3100, 0, 5'd4, 0, 1, 1, q, e);
    chk("eret_exc_req", {31'd0, q}, 32'd1);
    rd(12, 32'h0000_0403, "eret_exc_sr"); rd(13, 32'h0000_0010, "eret_exc_cause");

    // EPC bypass and ignored Cause write
    cyc(1, 1, 14, 32'h0000_3400, 0, 0, 0, 0, 0, 1, q, e);
    chk("epc_bypass", e, 32'h0000_3400);
    rd(14, 32'h0000_3400, "epc_wr");
    cyc(1, 1, 13, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1, q, e);
    rd(13, 32'h0000_0010, "cause_ro");
    chk("handler_pc", bus.handler_pc, HPC);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      rrn = ($urandom_range(0, 39) != 0);
      rw  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0: ra = 5'd12; 1: ra = 5'd13; 2: ra = 5'd14; 3: ra = 5'd15;
        default: ra = 5'($urandom_range(0, 31));
      endcase
      case ($urandom_range(0, 7))
        0: rx = 5'd4; 1: rx = 5'd5; 2: rx = 5'd10; 3: rx = 5'd12;
        default: rx = 5'd0;
      endcase
      rh  = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      rb  = 1'($urandom);
      rer = !rw && ($urandom_range(0, 5) == 0);
      cyc(rrn, rw, ra, $urandom, $urandom, rb, rx, rh, rer, 1, q, e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 SHALL have parameter PRID_VAL, default 32'h0000_4350, meaning PRId contents.
REQ-002 SHALL have parameter HANDLER_PC, default 32'h0000_4180, meaning the exception/interrupt entry vector.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port we  input  1  mtc0 write enable.
REQ-006 SHALL have port cp0_addr  input  5  CP0 register number for mtc0/mfc0.
REQ-007 SHALL have port din  input  32  mtc0 write data.
REQ-008 SHALL have port dout  output  32  mfc0 read data, combinational.
REQ-009 SHALL have port pc_m  input  32  PC of the instruction in M stage.
REQ-010 SHALL have port bd_m  input  1  M-stage instruction is in a branch delay slot.
REQ-011 SHALL have port excode_m  input  5  pipelined exception code, 0 = none; 10 = RI from decode.
REQ-012 SHALL have port hwint  input  6  external interrupt lines, level-sensitive.
REQ-013 SHALL have port eret  input  1  eret in M stage.
REQ-014 SHALL have port req  output  1  exception/interrupt taken this cycle, combinational.
REQ-015 SHALL have port epc_out  output  32  return address for eret.
REQ-016 SHALL have port handler_pc  output  32  constant HANDLER_PC.

Function
REQ-017 SHALL hold SR (reg 12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
REQ-018 SHALL hold Cause (reg 13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
REQ-019 SHALL hold EPC (reg 14, 32 bits) and return PRID_VAL for reg 15; any other address reads 0.
REQ-020 SHALL compute int_req = |(hwint & SR.IM) & SR.IE & !SR.EXL.
REQ-021 SHALL compute exc_req = (excode_m != 0) & !SR.EXL.
REQ-022 SHALL drive req = int_req | exc_req in the same cycle, with no register stage.
REQ-023 SHALL give interrupts priority over exceptions: if int_req, ExcCode is 0; otherwise ExcCode is excode_m.
REQ-024 SHALL, on a clock edge with req=1, set EXL, write ExcCode and BD=bd_m, and write EPC = bd_m ? {pc_m[31:2],2'b00}-4 : {pc_m[31:2],2'b00}.
REQ-025 SHALL update Cause.IP from hwint on every edge, independent of req and EXL.
REQ-026 SHALL, on an edge with eret=1 and req=0, clear EXL and leave all other fields unchanged.
REQ-027 SHALL, on an edge with we=1 and req=0, write SR (IM, EXL, IE only) or EPC (all 32 bits) per cp0_addr; writes to Cause, PRId and other addresses are ignored.
REQ-028 SHALL drop an mtc0 or eret that coincides with req=1, so the exception update wins.
REQ-029 SHALL drive epc_out = din when we=1 and cp0_addr=14 in the same cycle, and EPC otherwise.
REQ-030 SHALL, while EXL=1, accept no new interrupt or exception; excode_m is ignored.
REQ-031 SHALL make the mfc0 dout reflect register state before the current edge (no write-through).

Reset
REQ-032 SHALL, on an edge with reset=0, clear SR, Cause and EPC to 0; reset overrides req, we and eret.
REQ-033 SHALL hold req=0 during reset, because SR.IE=0 and SR.EXL=0 after the first reset edge and excode_m is gated by reset.

Structure
REQ-034 SHALL take CP0 register numbers (12-15), ExcCode values (0 Int, 4 AdEL, 5 AdES, 10 RI, 12 Ov) and the HANDLER_PC default from the shared pipeline definitions package.
REQ-035 SHALL contain one sub-module, cp0_irq_arb, which is combinational and computes int_req, exc_req, req and the selected ExcCode; all state stays in cp0_unit.

Verification
REQ-036 Bench SHALL cover: reset=0 for one edge, then read regs 12/13/14/15 -> 0, 0, 0, PRID_VAL.
REQ-037 Bench SHALL cover: mtc0 SR=32'h0000_0401, then hwint=6'b000001 -> req=1 the same cycle; after the edge, Cause.ExcCode=0, EXL=1, EPC=pc_m.
REQ-038 Bench SHALL cover: excode_m=10 with pc_m=32'h0000_3010, bd_m=1 -> req=1; EPC=32'h0000_300C, BD=1, ExcCode=10.
REQ-039 Bench SHALL cover: exception and interrupt in the same cycle with IE=1 -> ExcCode=0; then excode_m=12 while EXL=1 -> req=0 and no register change.
REQ-040 Bench SHALL cover: eret with EXL=1 -> EXL=0 after the edge; eret plus excode_m=4 in the same cycle -> EXL stays 1 and ExcCode=4.
REQ-041 Bench SHALL cover: mtc0 EPC=32'h0000_3400 in the same cycle as a read of epc_out -> epc_out=32'h0000_3400; mtc0 to Cause -> Cause unchanged.
